// File: rtl/reg_bank_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_sb_pkg
// Description : Shared defaults and index helpers for the integer register
//               bank and its pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_sb_pkg;

    // Default datapath geometry of the core's integer register file
    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int AW_DEF    = $clog2(NREG_DEF);

    // Index of the hardwired zero register
    localparam int ZERO_IDX  = 0;

    // Register index at default geometry
    typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage : reg_bank_sb_pkg
`default_nettype wire

// File: rtl/reg_bank_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_sb_scoreboard
// Description : In-order scoreboard of pending register writes. Keeps one
//               busy bit per register plus a running count of busy bits and
//               qualifies the busy view of the two read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_sb_scoreboard
    import reg_bank_sb_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_dir_a,
    input  logic [AW-1:0] i_dir_b,
    input  logic          i_reg_wr,
    input  logic [AW-1:0] i_dir_wr,
    input  logic          i_issue,
    input  logic [AW-1:0] i_dir_iss,
    input  logic          i_flush,
    output logic          o_busy_a,
    output logic          o_busy_b,
    output logic [AW:0]   o_pend_cnt
);

    localparam logic [AW-1:0] c_zero_idx = AW'(ZERO_IDX);
    localparam logic [AW:0]   c_one      = (AW+1)'(1);

    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_pend;

    logic w_set;
    logic w_inc;
    logic w_dec;

    // Decide whether this cycle raises or drops a busy bit so the counter
    // tracks the popcount without summing the whole vector.
    always_comb begin
        w_set = i_issue && !((ZERO_REG != 0) && (i_dir_iss == c_zero_idx));
        w_inc = w_set && !r_busy[i_dir_iss];
        // A write to the register being re-issued leaves it busy (new producer)
        w_dec = i_reg_wr && r_busy[i_dir_wr]
                && !(w_set && (i_dir_iss == i_dir_wr));
    end

    // Busy vector: clear on write-back, set on issue (set wins), flush clears all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            if (i_reg_wr) begin
                r_busy[i_dir_wr] <= 1'b0;
            end
            if (w_set) begin
                r_busy[i_dir_iss] <= 1'b1;
            end
        end
    end

    // Pending count: net of one possible rise and one possible fall per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (i_flush) begin
            r_pend <= '0;
        end else if (w_inc && !w_dec) begin
            r_pend <= r_pend + c_one;
        end else if (w_dec && !w_inc) begin
            r_pend <= r_pend - c_one;
        end
    end

    // A write-back landing this cycle already satisfies the reader via bypass
    always_comb begin
        o_busy_a = r_busy[i_dir_a] && !(i_reg_wr && (i_dir_wr == i_dir_a))
                   && !((ZERO_REG != 0) && (i_dir_a == c_zero_idx));
        o_busy_b = r_busy[i_dir_b] && !(i_reg_wr && (i_dir_wr == i_dir_b))
                   && !((ZERO_REG != 0) && (i_dir_b == c_zero_idx));
    end

    assign o_pend_cnt = r_pend;

endmodule : reg_bank_sb_scoreboard
`default_nettype wire

// File: rtl/reg_bank_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_sb
// Description : Parametrised integer register file with hardwired zero
//               register, write-through read bypass, asynchronous clear and
//               an in-order scoreboard of pending writes.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_sb
    import reg_bank_sb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   DIR_A,
    input  logic [AW-1:0]   DIR_B,
    output logic [XLEN-1:0] DOA,
    output logic [XLEN-1:0] DOB,
    output logic            BUSY_A,
    output logic            BUSY_B,
    input  logic            REG_WR,
    input  logic [AW-1:0]   DIR_WR,
    input  logic [XLEN-1:0] DI,
    input  logic            ISSUE,
    input  logic [AW-1:0]   DIR_ISS,
    input  logic            FLUSH,
    output logic [AW:0]     PEND_CNT
);

    localparam logic [AW-1:0] c_zero_idx = AW'(ZERO_IDX);

    logic [XLEN-1:0] r_regfile [NREG];
    logic            w_wr_en;

    // Writes to the hardwired zero register are dropped
    assign w_wr_en = REG_WR && !((ZERO_REG != 0) && (DIR_WR == c_zero_idx));

    // Data array: async clear, single write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regfile[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regfile[DIR_WR] <= DI;
        end
    end

    // Read ports: zero register, then same-cycle write bypass, then array
    always_comb begin
        if ((ZERO_REG != 0) && (DIR_A == c_zero_idx)) begin
            DOA = '0;
        end else if (REG_WR && (DIR_WR == DIR_A)) begin
            DOA = DI;
        end else begin
            DOA = r_regfile[DIR_A];
        end

        if ((ZERO_REG != 0) && (DIR_B == c_zero_idx)) begin
            DOB = '0;
        end else if (REG_WR && (DIR_WR == DIR_B)) begin
            DOB = DI;
        end else begin
            DOB = r_regfile[DIR_B];
        end
    end

    reg_bank_sb_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_dir_a    (DIR_A),
        .i_dir_b    (DIR_B),
        .i_reg_wr   (REG_WR),
        .i_dir_wr   (DIR_WR),
        .i_issue    (ISSUE),
        .i_dir_iss  (DIR_ISS),
        .i_flush    (FLUSH),
        .o_busy_a   (BUSY_A),
        .o_busy_b   (BUSY_B),
        .o_pend_cnt (PEND_CNT)
    );

endmodule : reg_bank_sb
`default_nettype wire

// File: tb/tb_reg_bank_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_sb
// Description : Self-checking bench for reg_bank_sb with a behavioural
//               register/busy model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   DIR_A = '0, DIR_B = '0, DIR_WR = '0, DIR_ISS = '0;
    logic [XLEN-1:0] DI = '0;
    logic            REG_WR = 1'b0, ISSUE = 1'b0, FLUSH = 1'b0;
    logic [XLEN-1:0] DOA, DOB;
    logic            BUSY_A, BUSY_B;
    logic [AW:0]     PEND_CNT;

    int n_vec  = 0;
    int n_fail = 0;

    reg_bank_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .DIR_A(DIR_A), .DIR_B(DIR_B), .DOA(DOA), .DOB(DOB),
        .BUSY_A(BUSY_A), .BUSY_B(BUSY_B),
        .REG_WR(REG_WR), .DIR_WR(DIR_WR), .DI(DI),
        .ISSUE(ISSUE), .DIR_ISS(DIR_ISS), .FLUSH(FLUSH),
        .PEND_CNT(PEND_CNT)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_reg  [NREG];
    logic            m_busy [NREG];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (REG_WR && DIR_WR != 0) m_reg[DIR_WR] = DI;
            if (FLUSH) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (REG_WR) m_busy[DIR_WR] = 1'b0;
                if (ISSUE && DIR_ISS != 0) m_busy[DIR_ISS] = 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (REG_WR && DIR_WR == a) return DI;
        return m_reg[a];
    endfunction

    function automatic logic m_busy_q(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(REG_WR && DIR_WR == a);
    endfunction

    function automatic int m_pend();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every negedge outside reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_DOA",    DOA, m_read(DIR_A));
            chk("m_DOB",    DOB, m_read(DIR_B));
            chk("m_BUSY_A", {31'd0, BUSY_A}, {31'd0, m_busy_q(DIR_A)});
            chk("m_BUSY_B", {31'd0, BUSY_B}, {31'd0, m_busy_q(DIR_B)});
            chk("m_PEND",   {26'd0, PEND_CNT}, m_pend());
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [XLEN-1:0] d,
                         input logic iss, input logic [AW-1:0] ia, input logic fl,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        REG_WR = wr; DIR_WR = wa; DI = d;
        ISSUE = iss; DIR_ISS = ia; FLUSH = fl;
        DIR_A = a; DIR_B = b;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 5, 31);
        step(); step();
        rst = 1'b0;
        // Reset state
        chk("rst_DOA", DOA, 32'h0);
        chk("rst_DOB", DOB, 32'h0);
        chk("rst_BUSY", {30'd0, BUSY_A, BUSY_B}, 32'h0);
        chk("rst_PEND", {26'd0, PEND_CNT}, 32'h0);

        // Bypass and persistence
        drive(1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 5);
        chk("byp_DOA", DOA, 32'hDEADBEEF);
        step();
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        chk("held_DOA", DOA, 32'hDEADBEEF);
        chk("held_DOB", DOB, 32'hDEADBEEF);

        // Zero register
        drive(1, 0, 32'h1234, 0, 0, 0, 0, 0);
        chk("zero_byp", DOA, 32'h0);
        step();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        chk("zero_arr", DOA, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("zero_busy", {31'd0, BUSY_A}, 32'h0);
        chk("zero_pend", {26'd0, PEND_CNT}, 32'h0);

        // Issue x3, x4; re-issue while writing x3; write x4
        drive(0, 0, 0, 1, 3, 0, 3, 4);
        step();
        drive(0, 0, 0, 1, 4, 0, 3, 4);
        step();
        drive(0, 0, 0, 0, 0, 0, 3, 4);
        chk("iss_pend2", {26'd0, PEND_CNT}, 32'd2);
        chk("iss_busy34", {30'd0, BUSY_A, BUSY_B}, 32'h3);
        drive(1, 3, 32'h33, 1, 3, 0, 3, 4);
        chk("wr3_busyA_byp", {31'd0, BUSY_A}, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 3, 4);
        chk("setwins_busy3", {31'd0, BUSY_A}, 32'h1);
        chk("setwins_pend", {26'd0, PEND_CNT}, 32'd2);
        drive(1, 4, 32'h44, 0, 0, 0, 3, 4);
        chk("wr4_busyB_drop", {31'd0, BUSY_B}, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 3, 4);
        chk("wr4_pend1", {26'd0, PEND_CNT}, 32'd1);
        // Set x5 and clear x3 in one cycle: count unchanged
        drive(1, 3, 32'h333, 1, 5, 0, 3, 5);
        step();
        drive(0, 0, 0, 0, 0, 0, 3, 5);
        chk("setclr_pend", {26'd0, PEND_CNT}, 32'd1);
        // Issue to already-busy x5, write non-busy x6
        drive(1, 6, 32'h66, 1, 5, 0, 6, 5);
        step();
        drive(0, 0, 0, 0, 0, 0, 6, 5);
        chk("dbl_iss_pend", {26'd0, PEND_CNT}, 32'd1);
        chk("nonbusy_wr_data", DOA, 32'h66);
        drive(1, 5, 32'h55, 0, 0, 0, 6, 5);
        step();

        // Ten issues then flush with concurrent write
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 0, 1, AW'(i), 0, AW'(i), 1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 10, 1);
        chk("ten_pend", {26'd0, PEND_CNT}, 32'd10);
        drive(1, 2, 32'h55, 0, 0, 1, 2, 9);
        step();
        drive(0, 0, 0, 0, 0, 0, 2, 9);
        chk("flush_pend", {26'd0, PEND_CNT}, 32'd0);
        chk("flush_data", DOA, 32'h55);
        chk("flush_busy", {30'd0, BUSY_A, BUSY_B}, 32'h0);
        step();

        // Async reset mid-cycle
        drive(1, 9, 32'hA5A5A5A5, 0, 0, 0, 9, 9);
        step();
        drive(0, 0, 0, 1, 9, 0, 9, 9);
        chk("pre_rst_DOA", DOA, 32'hA5A5A5A5);
        step();
        drive(0, 0, 0, 0, 0, 0, 9, 9);
        chk("pre_rst_busy", {31'd0, BUSY_A}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_DOA", DOA, 32'h0);
        chk("arst_BUSY", {30'd0, BUSY_A, BUSY_B}, 32'h0);
        chk("arst_PEND", {26'd0, PEND_CNT}, 32'h0);
        step();
        rst = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_reg_bank_sb
`default_nettype wire

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised integer register file with hardwired zero register, write-through read bypass, asynchronous clear and an in-order scoreboard of pending writes. It sits between decode/issue (read ports, busy query, issue marking) and write-back (write port, busy release). It replaces the fixed 32×32 bank in the core datapath.

## Interface
Parameters:
- XLEN, 32, data width of every register.
- NREG, 32, number of registers (power of two, ≥ 2).
- AW, $clog2(NREG), address width (derived; do not override).
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never busy.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- DIR_A  in  AW  read address port A (rs1).
- DIR_B  in  AW  read address port B (rs2).
- DOA  out  XLEN  read data A.
- DOB  out  XLEN  read data B.
- BUSY_A  out  1  register at DIR_A has a pending write.
- BUSY_B  out  1  register at DIR_B has a pending write.
- REG_WR  in  1  write-back enable.
- DIR_WR  in  AW  write-back address (rd).
- DI  in  XLEN  write-back data.
- ISSUE  in  1  mark DIR_ISS pending.
- DIR_ISS  in  AW  issuing instruction's rd.
- FLUSH  in  1  synchronous clear of all busy bits.
- PEND_CNT  out  AW+1  number of registers currently busy.

## Operation
- Storage: NREG×XLEN array `regfile` plus NREG-bit `busy` vector and AW+1-bit counter `pend`.
- Write: at rising clk, if REG_WR and not (ZERO_REG and DIR_WR==0), regfile[DIR_WR] <= DI.
- Read: combinational. DOA = 0 if ZERO_REG and DIR_A==0; else DI if REG_WR and DIR_WR==DIR_A (bypass); else regfile[DIR_A]. DOB identical with DIR_B.
- Busy set: ISSUE with DIR_ISS≠0 (or ZERO_REG=0) sets busy[DIR_ISS] next edge.
- Busy clear: REG_WR clears busy[DIR_WR] next edge.
- Same register issued and written in one cycle: set wins (busy stays 1; new producer).
- Issue to an already-busy register: busy stays 1, pend unchanged (no double count).
- Write to a non-busy register: data written, pend unchanged.
- BUSY_A = busy[DIR_A] and not (REG_WR and DIR_WR==DIR_A); same for B (write-back this cycle satisfies the reader via bypass). Register 0 with ZERO_REG=1: always 0.
- FLUSH: all busy <= 0, pend <= 0; overrides ISSUE/REG_WR busy updates that cycle; REG_WR data write still occurs.
- pend tracks popcount(busy) exactly: +1 on 0→1, −1 on 1→0, net of simultaneous set and clear on different registers (one set + one clear = unchanged). Never exceeds NREG (NREG−1 with ZERO_REG).

## Timing
- Reset (async assert, sync-safe deassert by upstream): regfile all 0, busy all 0, PEND_CNT=0; DOA/DOB=0 and BUSY_A/B=0 for any address.
- Read latency 0 cycles (combinational, including bypass path).
- Write visible in array one edge after REG_WR; visible on DOA/DOB same cycle via bypass.
- Busy set/clear and PEND_CNT update one edge after ISSUE/REG_WR/FLUSH.
- Reset mid-operation: all state clears immediately regardless of pending issues/writes; no write in flight survives.

## Structure
- Shared core package: XLEN and NREG defaults, register-index type, ZERO_REG index constant.
- One sub-module natural: reg_scoreboard (busy vector + pend counter + BUSY_A/B qualification); data array, bypass muxes kept in reg_bank_sb.

## Test plan
- Reset then read DIR_A=5, DIR_B=31 -> DOA=0, DOB=0, BUSY_A=BUSY_B=0, PEND_CNT=0.
- REG_WR, DIR_WR=7, DI=0xDEADBEEF, DIR_A=7 same cycle -> DOA=0xDEADBEEF combinationally; next cycle with REG_WR=0 still 0xDEADBEEF.
- Write DI=0x1234 to DIR_WR=0, read DIR_A=0 -> DOA=0 both cycles; ISSUE DIR_ISS=0 -> BUSY_A=0, PEND_CNT=0.
- ISSUE x3, next cycle ISSUE x4 -> PEND_CNT=2, BUSY for 3 and 4; then REG_WR x3 with ISSUE x3 same cycle -> busy[3] stays 1, PEND_CNT=2; REG_WR x4 -> PEND_CNT=1, BUSY for x4 drops during the write cycle.
- ISSUE x1..x10 over ten cycles -> PEND_CNT=10; FLUSH with REG_WR x2 DI=0x55 -> PEND_CNT=0, all busy 0, regfile[2]=0x55.
- Write x9=0xA5A5A5A5, ISSUE x9, assert rst asynchronously mid-cycle -> DOA(x9)=0, BUSY=0, PEND_CNT=0 before next edge.
